// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the opcode values, the FSM state encodings, and the mux-select and
// ALU-op encodings. The ALU decoder and the datapath muxes use the same
// encodings. Also holds the packed control bundle produced by the output
// decoder.
package mips_mc_control_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  // Opcode field values (instr[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTEXEC = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11
  } state_t;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // ALUOp encoding seen by the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // PCSrc select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Raw per-state control bundle. pc_write and branch are combined with the
  // ALU zero flag in the top to form PCEn.
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state -> control decode for the multi-cycle MIPS FSM.
// Ports:
//   i_state     current FSM state
//   i_mem_ready memory handshake; qualifies the fetch-cycle IR and PC loads
//   o_ctrl      raw control bundle. Selects not used in a state are driven 0.
//               Unencoded states decode to all zero.
module mips_mc_outdec
  import mips_mc_control_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_mem_ready,
  output ctrl_t              o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PCSRC_ALU;
        // IR and PC only load once the instruction word has actually arrived
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      ST_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        // The write strobe is held for the whole wait on mem_ready
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      ST_RTEXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_src    = PCSRC_ALUOUT;
        o_ctrl.branch    = 1'b1;
      end
      ST_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      ST_JUMP: begin
        o_ctrl.pc_src   = PCSRC_JUMP;
        o_ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM.
// Moves each instruction through the fetch, decode, execute, memory and
// writeback steps. It stalls on mem_ready while fetching an instruction,
// during a load read and during a store write.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode          instr[31:26] from the instruction register
//   zero            ALU zero flag, used for BEQ
//   mem_ready       memory access completes this cycle
//   IorD/MemWrite/IRWrite/RegDst/MemtoReg/RegWrite/ALUSrcA/ALUSrcB/ALUOp/
//   PCSrc/PCEn      datapath controls. All of them are forced to 0 while reset is high.
//   illegal_op      one-cycle pulse in DECODE for an unknown opcode
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            IorD,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            PCEn,
  output logic            illegal_op
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_next;
  logic            w_illegal;
  ctrl_t           w_ctrl;
  ctrl_t           w_ctrl_gated;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = ST_FETCH;
    w_illegal    = 1'b0;
    case (r_state)
      ST_FETCH:  w_state_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_state_next = ST_MEMADR;
          OP_RTYPE:     w_state_next = ST_RTEXEC;
          OP_BEQ:       w_state_next = ST_BRANCH;
          OP_ADDI:      w_state_next = ST_ADDIEX;
          OP_J:         w_state_next = ST_JUMP;
          default:      w_state_next = ST_FETCH;
        endcase
        // DECODE lasts exactly one cycle, so this is a single-cycle pulse
        w_illegal = !is_known_op(opcode);
      end
      ST_MEMADR: begin
        if (opcode == OP_LW) begin
          w_state_next = ST_MEMRD;
        end else if (opcode == OP_SW) begin
          w_state_next = ST_MEMWR;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_MEMRD:  w_state_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  w_state_next = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTEXEC: w_state_next = ST_ALUWB;
      ST_ADDIEX: w_state_next = ST_ADDIWB;
      // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP and unencoded states all go back to FETCH
      default:   w_state_next = ST_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset gates every output combinationally. Nothing can be written
  // during the reset cycles, even while the state register still holds
  // the state of the aborted instruction.
  assign w_ctrl_gated = reset ? '0 : w_ctrl;

  assign IorD       = w_ctrl_gated.iord;
  assign MemWrite   = w_ctrl_gated.mem_write;
  assign IRWrite    = w_ctrl_gated.ir_write;
  assign RegDst     = w_ctrl_gated.reg_dst;
  assign MemtoReg   = w_ctrl_gated.mem_to_reg;
  assign RegWrite   = w_ctrl_gated.reg_write;
  assign ALUSrcA    = w_ctrl_gated.alu_src_a;
  assign ALUSrcB    = w_ctrl_gated.alu_src_b;
  assign ALUOp      = w_ctrl_gated.alu_op;
  assign PCSrc      = w_ctrl_gated.pc_src;
  assign PCEn       = w_ctrl_gated.pc_write | (w_ctrl_gated.branch & zero);
  assign illegal_op = w_illegal & ~reset;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control. Each cycle applies inputs, then
// compares the FSM state and the full control vector against hand-computed
// values.
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  mips_mc_control #(.OP_W(6), .ST_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,illegal_op}
  logic [14:0] w_ctl;
  assign w_ctl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op};

  //                                iord mw   irw  rd   m2r  rw   sa   sb    aop   pcs   pcen ill
  localparam logic [14:0] C_ZERO   = 15'd0;
  localparam logic [14:0] C_FETCH  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b1,1'b0};
  localparam logic [14:0] C_FSTALL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_ILL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd0,2'd0,1'b0,1'b1};
  localparam logic [14:0] C_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_MEMRD  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_MEMWR  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_RTEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd2,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_ALUWB  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_BR_T   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,2'd1,1'b1,1'b0};
  localparam logic [14:0] C_BR_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,2'd1,1'b0,1'b0};
  localparam logic [14:0] C_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0};
  localparam logic [14:0] C_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd2,1'b1,1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, settle, compare, then advance to the next negedge.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic z, input logic mr, input logic [3:0] exp_st,
                     input logic [14:0] exp_ctl);
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    #1;
    $display("[TB] %s st=%0d ctl=%04h", tag, dut.r_state, w_ctl);
    check({tag, ".state"}, 32'(dut.r_state), 32'(exp_st));
    check({tag, ".ctl"}, 32'(w_ctl), 32'(exp_ctl));
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = OP_RTYPE;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);

    // Reset: outputs forced low even with mem_ready high
    cyc("rst0",       1, OP_RTYPE, 0, 1, ST_FETCH,  C_ZERO);
    cyc("rst1",       1, OP_RTYPE, 0, 1, ST_FETCH,  C_ZERO);

    // R-type aborted by 3 reset cycles while in RTEXEC
    cyc("rA.fetch",   0, OP_RTYPE, 0, 1, ST_FETCH,  C_FETCH);
    cyc("rA.decode",  0, OP_RTYPE, 0, 1, ST_DECODE, C_DECODE);
    cyc("rA.rst1",    1, OP_RTYPE, 0, 1, ST_RTEXEC, C_ZERO);
    cyc("rA.rst2",    1, OP_RTYPE, 0, 1, ST_FETCH,  C_ZERO);
    cyc("rA.rst3",    1, OP_RTYPE, 0, 1, ST_FETCH,  C_ZERO);

    // Full R-type
    cyc("r.fetch",    0, OP_RTYPE, 0, 1, ST_FETCH,  C_FETCH);
    cyc("r.decode",   0, OP_RTYPE, 0, 1, ST_DECODE, C_DECODE);
    cyc("r.exec",     0, OP_RTYPE, 0, 1, ST_RTEXEC, C_RTEX);
    cyc("r.wb",       0, OP_RTYPE, 0, 1, ST_ALUWB,  C_ALUWB);

    // LW, no stalls
    cyc("lw.fetch",   0, OP_LW,    0, 1, ST_FETCH,  C_FETCH);
    cyc("lw.decode",  0, OP_LW,    0, 1, ST_DECODE, C_DECODE);
    cyc("lw.adr",     0, OP_LW,    0, 1, ST_MEMADR, C_MEMADR);
    cyc("lw.rd",      0, OP_LW,    0, 1, ST_MEMRD,  C_MEMRD);
    cyc("lw.wb",      0, OP_LW,    0, 1, ST_MEMWB,  C_MEMWB);

    // LW with one fetch stall and one read stall
    cyc("lw2.fstall", 0, OP_LW,    0, 0, ST_FETCH,  C_FSTALL);
    cyc("lw2.fetch",  0, OP_LW,    0, 1, ST_FETCH,  C_FETCH);
    cyc("lw2.decode", 0, OP_LW,    0, 1, ST_DECODE, C_DECODE);
    cyc("lw2.adr",    0, OP_LW,    0, 1, ST_MEMADR, C_MEMADR);
    cyc("lw2.rdwait", 0, OP_LW,    0, 0, ST_MEMRD,  C_MEMRD);
    cyc("lw2.rd",     0, OP_LW,    0, 1, ST_MEMRD,  C_MEMRD);
    cyc("lw2.wb",     0, OP_LW,    0, 1, ST_MEMWB,  C_MEMWB);

    // SW, memory holds off for 2 cycles
    cyc("sw.fetch",   0, OP_SW,    0, 1, ST_FETCH,  C_FETCH);
    cyc("sw.decode",  0, OP_SW,    0, 1, ST_DECODE, C_DECODE);
    cyc("sw.adr",     0, OP_SW,    0, 1, ST_MEMADR, C_MEMADR);
    cyc("sw.wr0",     0, OP_SW,    0, 0, ST_MEMWR,  C_MEMWR);
    cyc("sw.wr1",     0, OP_SW,    0, 0, ST_MEMWR,  C_MEMWR);
    cyc("sw.wr2",     0, OP_SW,    0, 1, ST_MEMWR,  C_MEMWR);

    // BEQ taken (fetch also confirms MemWrite dropped after SW)
    cyc("beqT.fetch", 0, OP_BEQ,   1, 1, ST_FETCH,  C_FETCH);
    cyc("beqT.dec",   0, OP_BEQ,   1, 1, ST_DECODE, C_DECODE);
    cyc("beqT.br",    0, OP_BEQ,   1, 1, ST_BRANCH, C_BR_T);

    // BEQ not taken
    cyc("beqN.fetch", 0, OP_BEQ,   0, 1, ST_FETCH,  C_FETCH);
    cyc("beqN.dec",   0, OP_BEQ,   0, 1, ST_DECODE, C_DECODE);
    cyc("beqN.br",    0, OP_BEQ,   0, 1, ST_BRANCH, C_BR_N);

    // J
    cyc("j.fetch",    0, OP_J,     0, 1, ST_FETCH,  C_FETCH);
    cyc("j.decode",   0, OP_J,     0, 1, ST_DECODE, C_DECODE);
    cyc("j.jump",     0, OP_J,     0, 1, ST_JUMP,   C_JUMP);

    // ADDI
    cyc("addi.fetch", 0, OP_ADDI,  0, 1, ST_FETCH,  C_FETCH);
    cyc("addi.dec",   0, OP_ADDI,  0, 1, ST_DECODE, C_DECODE);
    cyc("addi.ex",    0, OP_ADDI,  0, 1, ST_ADDIEX, C_ADDIEX);
    cyc("addi.wb",    0, OP_ADDI,  0, 1, ST_ADDIWB, C_ADDIWB);

    // Illegal opcode: single pulse in DECODE, then straight back to FETCH
    cyc("ill.fetch",  0, 6'h3F,    0, 1, ST_FETCH,  C_FETCH);
    cyc("ill.decode", 0, 6'h3F,    0, 1, ST_DECODE, C_ILL);
    cyc("ill.after",  0, 6'h3F,    0, 1, ST_FETCH,  C_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
